// File: rtl/writeback_regfile.sv
// Writeback stage: commits memory-stage results to the 32x32 GPR file or HI/LO,
// provides bypassed read ports plus a registered commit trace and saturating commit counter.
module writeback_regfile #(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      MW_ALUout,
  input  logic [31:0]      MW_ALUoutBK,
  input  logic [4:0]       MW_RD,
  input  logic [2:0]       FD_MemCtr,
  input  logic [4:0]       RS_Addr,
  input  logic [4:0]       RT_Addr,
  output logic [31:0]      RS_Data,
  output logic [31:0]      RT_Data,
  output logic [31:0]      HI_Data,
  output logic [31:0]      LO_Data,
  output logic             WB_We,
  output logic [4:0]       WB_RD,
  output logic [31:0]      WB_Data,
  output logic [CNT_W-1:0] WB_Count
);

  localparam logic [2:0] CTR_HILO = 3'd6;

  logic        gpr_we;
  logic        hilo_we;
  logic [31:0] rf_reg [NREG];
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [4:0]  rd_addr [2];
  logic [31:0] rd_data [2];

  // Writes to register 0 are dropped here, so it never counts or traces either.
  assign gpr_we  = ((FD_MemCtr == 3'd0) || (FD_MemCtr == 3'd1)) && (MW_RD != 5'd0);
  assign hilo_we = (FD_MemCtr == CTR_HILO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
    end else if (gpr_we) begin
      rf_reg[MW_RD] <= MW_ALUout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (hilo_we) begin
      hi_reg <= MW_ALUoutBK;
      lo_reg <= MW_ALUout;
    end
  end

  assign rd_addr[0] = RS_Addr;
  assign rd_addr[1] = RT_Addr;

  // Both read ports share the same write-through bypass against this cycle's commit.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      always_comb begin
        rd_data[gi] = rf_reg[rd_addr[gi]];
        if (rd_addr[gi] == 5'd0)
          rd_data[gi] = '0;
        else if (gpr_we && (rd_addr[gi] == MW_RD))
          rd_data[gi] = MW_ALUout;
      end
    end
  endgenerate

  assign RS_Data = rd_data[0];
  assign RT_Data = rd_data[1];
  assign HI_Data = hilo_we ? MW_ALUoutBK : hi_reg;
  assign LO_Data = hilo_we ? MW_ALUout   : lo_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WB_We   <= 1'b0;
      WB_RD   <= '0;
      WB_Data <= '0;
    end else begin
      WB_We <= gpr_we;
      if (gpr_we) begin
        WB_RD   <= MW_RD;
        WB_Data <= MW_ALUout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      WB_Count <= '0;
    else if ((gpr_we || hilo_we) && (WB_Count != {CNT_W{1'b1}}))
      WB_Count <= WB_Count + CNT_W'(1);
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: default instance plus a CNT_W=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] MW_ALUout;
  logic [31:0] MW_ALUoutBK;
  logic [4:0]  MW_RD;
  logic [2:0]  FD_MemCtr;
  logic [4:0]  RS_Addr;
  logic [4:0]  RT_Addr;
  logic [31:0] RS_Data, RT_Data, HI_Data, LO_Data, WB_Data;
  logic        WB_We;
  logic [4:0]  WB_RD;
  logic [15:0] WB_Count;

  logic [31:0] s_rs, s_rt, s_hi, s_lo, s_wbdata;
  logic        s_we;
  logic [4:0]  s_rd;
  logic [1:0]  s_count;

  int n_cmp = 0;
  int n_bad = 0;

  writeback_regfile dut (
    .clk(clk), .rst(rst), .MW_ALUout(MW_ALUout), .MW_ALUoutBK(MW_ALUoutBK),
    .MW_RD(MW_RD), .FD_MemCtr(FD_MemCtr), .RS_Addr(RS_Addr), .RT_Addr(RT_Addr),
    .RS_Data(RS_Data), .RT_Data(RT_Data), .HI_Data(HI_Data), .LO_Data(LO_Data),
    .WB_We(WB_We), .WB_RD(WB_RD), .WB_Data(WB_Data), .WB_Count(WB_Count)
  );

  writeback_regfile #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .MW_ALUout(MW_ALUout), .MW_ALUoutBK(MW_ALUoutBK),
    .MW_RD(MW_RD), .FD_MemCtr(FD_MemCtr), .RS_Addr(RS_Addr), .RT_Addr(RT_Addr),
    .RS_Data(s_rs), .RT_Data(s_rt), .HI_Data(s_hi), .LO_Data(s_lo),
    .WB_We(s_we), .WB_RD(s_rd), .WB_Data(s_wbdata), .WB_Count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] ctr, input logic [4:0] rd,
                       input logic [31:0] lo, input logic [31:0] hi);
    FD_MemCtr   = ctr;
    MW_RD       = rd;
    MW_ALUout   = lo;
    MW_ALUoutBK = hi;
    $display("txn ctr=%0d rd=%0d alu=0x%08h bk=0x%08h", ctr, rd, lo, hi);
  endtask

  // Advance past the next rising edge; outputs then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    RS_Addr = '0;
    RT_Addr = '0;
    drive(3'd7, 5'd0, 32'h0, 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Reset state
    for (int i = 0; i < 32; i++) begin
      RS_Addr = 5'(i);
      RT_Addr = 5'(31 - i);
      #1;
      check($sformatf("rst_rs%0d", i), RS_Data, 32'h0);
      check($sformatf("rst_rt%0d", 31 - i), RT_Data, 32'h0);
    end
    check("rst_hi", HI_Data, 32'h0);
    check("rst_lo", LO_Data, 32'h0);
    check("rst_we", {31'h0, WB_We}, 32'h0);
    check("rst_cnt", {16'h0, WB_Count}, 32'h0);
    check("rst_sat_cnt", {30'h0, s_count}, 32'h0);

    // GPR write to R5 with same-cycle bypass, then from storage
    drive(3'd0, 5'd5, 32'h1234_5678, 32'h0);
    RS_Addr = 5'd5;
    RT_Addr = 5'd6;
    #1;
    check("byp_r5", RS_Data, 32'h1234_5678);
    check("nobyp_r6", RT_Data, 32'h0);
    tick();
    drive(3'd7, 5'd5, 32'h0, 32'h0);
    #1;
    check("store_r5", RS_Data, 32'h1234_5678);
    check("trace_we", {31'h0, WB_We}, 32'h1);
    check("trace_rd", {27'h0, WB_RD}, 32'd5);
    check("trace_data", WB_Data, 32'h1234_5678);
    check("cnt_1", {16'h0, WB_Count}, 32'd1);
    check("sat_cnt_1", {30'h0, s_count}, 32'd1);

    // Write to R0 is dropped
    drive(3'd1, 5'd0, 32'hFFFF_FFFF, 32'h0);
    RS_Addr = 5'd0;
    RT_Addr = 5'd0;
    #1;
    check("r0_byp_rs", RS_Data, 32'h0);
    check("r0_byp_rt", RT_Data, 32'h0);
    tick();
    drive(3'd7, 5'd0, 32'h0, 32'h0);
    #1;
    check("r0_store", RS_Data, 32'h0);
    check("r0_we", {31'h0, WB_We}, 32'h0);
    check("r0_rd_hold", {27'h0, WB_RD}, 32'd5);
    check("r0_cnt", {16'h0, WB_Count}, 32'd1);

    // HI/LO write with stale MW_RD=9
    drive(3'd6, 5'd9, 32'hAAAA_0000, 32'h0000_BBBB);
    RS_Addr = 5'd9;
    #1;
    check("hi_byp", HI_Data, 32'h0000_BBBB);
    check("lo_byp", LO_Data, 32'hAAAA_0000);
    check("hilo_r9_byp", RS_Data, 32'h0);
    tick();
    drive(3'd7, 5'd9, 32'h0, 32'h0);
    #1;
    check("hi_held", HI_Data, 32'h0000_BBBB);
    check("lo_held", LO_Data, 32'hAAAA_0000);
    check("hilo_r9", RS_Data, 32'h0);
    check("hilo_we", {31'h0, WB_We}, 32'h0);
    check("hilo_cnt", {16'h0, WB_Count}, 32'd2);

    // Back-to-back writes to R3, then a store to R3
    drive(3'd0, 5'd3, 32'h1, 32'h0);
    RS_Addr = 5'd3;
    RT_Addr = 5'd3;
    #1;
    check("b2b_byp1", RS_Data, 32'h1);
    tick();
    drive(3'd0, 5'd3, 32'h2, 32'h0);
    #1;
    check("b2b_byp2_rs", RS_Data, 32'h2);
    check("b2b_byp2_rt", RT_Data, 32'h2);
    tick();
    drive(3'd2, 5'd3, 32'hDEAD_BEEF, 32'h0);
    #1;
    check("store_nobyp", RS_Data, 32'h2);
    check("b2b_trace", WB_Data, 32'h2);
    tick();
    drive(3'd7, 5'd3, 32'h0, 32'h0);
    #1;
    check("b2b_r3", RS_Data, 32'h2);
    check("store_we", {31'h0, WB_We}, 32'h0);
    check("store_cnt", {16'h0, WB_Count}, 32'd4);
    check("sat_cnt_4", {30'h0, s_count}, 32'd3);

    // Codes 3..5 change nothing
    RS_Addr = 5'd7;
    for (int c = 3; c <= 5; c++) begin
      drive(3'(c), 5'd7, 32'h5555_0000 + 32'(c), 32'h6666_0000);
      tick();
    end
    drive(3'd7, 5'd7, 32'h0, 32'h0);
    #1;
    check("code345_r7", RS_Data, 32'h0);
    check("code345_hi", HI_Data, 32'h0000_BBBB);
    check("code345_cnt", {16'h0, WB_Count}, 32'd4);

    // Five more GPR writes; narrow counter stays saturated
    for (int k = 0; k < 5; k++) begin
      drive(3'd0, 5'(10 + k), 32'hC0DE_0000 + 32'(k), 32'h0);
      tick();
    end
    check("sat_hold", {30'h0, s_count}, 32'd3);
    check("wide_cnt", {16'h0, WB_Count}, 32'd9);
    check("last_we", {31'h0, WB_We}, 32'h1);
    check("last_rd", {27'h0, WB_RD}, 32'd14);

    // Asynchronous reset mid-cycle
    drive(3'd7, 5'd0, 32'h0, 32'h0);
    RS_Addr = 5'd3;
    RT_Addr = 5'd14;
    #1;
    rst = 1'b0;
    #1;
    check("arst_rs", RS_Data, 32'h0);
    check("arst_rt", RT_Data, 32'h0);
    check("arst_hi", HI_Data, 32'h0);
    check("arst_lo", LO_Data, 32'h0);
    check("arst_we", {31'h0, WB_We}, 32'h0);
    check("arst_rd", {27'h0, WB_RD}, 32'h0);
    check("arst_data", WB_Data, 32'h0);
    check("arst_cnt", {16'h0, WB_Count}, 32'h0);
    check("arst_sat_cnt", {30'h0, s_count}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
